video_capture: RTL
==================

// Module: video_capture
// PURPOSE
//  Receive end of the VGA link: takes hSync/vSync (active-low) + 8-bit videoData per pixel sample,
//  locks to the 812x525 timing and rebuilds the 320x240 pixel-pair framebuffer stream
//  (x = sample/2, y = row/2; even rows only). Feeds a framebuffer write port;
//  used for loopback test and capture of the VideoOutput stream.
// PARAMETERS
//  H_VISIBLE_AREA   640  active samples per line
//  H_TOTAL          812  samples per line (640+20+100+52)
//  H_ACTIVE_START   152  samples from hSync falling edge to first active sample (pulse+back porch)
//  V_VISIBLE_AREA   480  active rows per frame
//  V_TOTAL          525  lines per frame (480+10+2+33)
//  V_ACTIVE_START    34  index of hSync fall (0 = first after vSync fall) preceding row 0
//  LOCK_FRAMES        2  consecutive good frames required before locked
// PORTS
//  clock       in   1  system clock; all logic on posedge
//  reset       in   1  asynchronous, active-low reset
//  pixelValid  in   1  qualifies hSync/vSync/videoData as one pixel sample this cycle
//  hSync       in   1  horizontal sync, active-low
//  vSync       in   1  vertical sync, active-low
//  videoData   in   8  pixel sample
//  wrEnable    out  1  one-cycle write strobe for a pixel pair
//  wrX         out  9  pair column 0..319
//  wrY         out  8  row 0..239
//  wrPixel1    out  8  even-column sample of pair
//  wrPixel2    out  8  odd-column sample of pair
//  frameDone   out  1  one-cycle pulse with the write of (319,239)
//  locked      out  1  timing locked; writes only occur while 1
//  syncError   out  1  one-cycle pulse on line- or frame-length mismatch
// BEHAVIOUR
//  - Reset (reset=0): all outputs 0, counters 0, FSM=SEARCH, lockCount=0; immediate (async), incl. mid-line.
//  - Input stage: hSync/vSync/videoData/pixelValid registered once; edges detected on registered syncs
//    between consecutive valid samples. Cycles with pixelValid=0 change nothing (no counting, no edges).
//  - sampleCount: 0 on valid sample carrying hSync fall, +1 per valid sample after.
//    At next hSync fall: sampleCount+1 != H_TOTAL -> syncError pulse, locked=0, lockCount=0, FSM=SEARCH.
//  - lineCount: 0 at first hSync fall after vSync fall, +1 per hSync fall. At vSync fall: lineCount+1==V_TOTAL
//    -> lockCount++ (saturate LOCK_FRAMES), locked=1 when lockCount==LOCK_FRAMES; else syncError, unlock.
//  - FSM: SEARCH -(vSync fall)-> VBLANK -(hSync fall #V_ACTIVE_START)-> HBLANK
//    HBLANK -(sampleCount==H_ACTIVE_START-1)-> ACTIVE (next valid sample = column 0)
//    ACTIVE -(column 639 taken)-> LINE_END -(hSync fall)-> HBLANK, or SEARCH after row 479.
//    vSync fall in any state other than SEARCH/VBLANK restarts at VBLANK (lock check applied).
//  - Column c even: hold sample; c odd: on row r even and locked, register wrEnable=1,
//    wrX=c>>1, wrY=r>>1, wrPixel1=held, wrPixel2=sample. Odd rows never written.
//  - Latency: wrEnable high 2 clocks after the edge where odd sample was presented (input reg + output reg).
//  - wrX/wrY/wrPixel* hold last values when wrEnable=0. frameDone coincides with write (319,239).
//  - Simultaneous hSync and vSync fall on one sample: vSync handled first, that hSync is line 0.
//  - Lock lost mid-frame: current and further writes suppressed; no partial-frame frameDone.
// STRUCTURE
//  - video_timing_pkg: H_/V_ timing constants (shared with VideoOutput), capture FSM state enum.
//  - Sub-module sync_monitor: input register, edge detect, sampleCount/lineCount, lock + syncError.
//  - video_capture top: FSM, column/row counters, pair assembly and write register.
// TESTING
//  1 VideoOutput-format stream, pixel1=0x00 pixel2=0xFF, valid every cycle -> locked=1 after vSync fall
//    ending frame 2; frame 3: 76800 writes, first (0,0) last (319,239), all {0x00,0xFF}, one frameDone.
//  2 One line of 811 samples in locked frame -> syncError 1 cycle, locked=0, no writes until 2 good frames.
//  3 reset=0 at column 100 row 50 -> all outputs 0 at once; after release no write before re-lock.
//  4 pixelValid toggled 1/0 each cycle over frame 3 -> identical write sequence/data as scenario 1.
//  5 Frame with 524 lines -> syncError at vSync fall, locked=0, lockCount=0.
//  6 Odd rows carry 0xAA, even rows 0x11 -> every write data {0x11,0x11}; 0xAA never written.

Source files
------------

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: VGA 812x525 timing constants and capture FSM state encoding
package video_timing_pkg;
  localparam int H_VISIBLE_AREA = 640;
  localparam int H_TOTAL        = 812;
  localparam int H_ACTIVE_START = 152;
  localparam int V_VISIBLE_AREA = 480;
  localparam int V_TOTAL        = 525;
  localparam int V_ACTIVE_START = 34;
  localparam int LOCK_FRAMES    = 2;
  localparam int CNT_W          = 12;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [2:0] {SEARCH, VBLANK, HBLANK, ACTIVE, LINE_END} cap_state_t;
endpackage

// File: rtl/video_capture_sync_monitor.sv
// sync_monitor: input register, sync edge detect, line/frame length check and lock tracking
module sync_monitor
  import video_timing_pkg::*;
#(
  parameter int H_TOT  = H_TOTAL,
  parameter int V_TOT  = V_TOTAL,
  parameter int LOCK_N = LOCK_FRAMES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pixel_valid,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic [7:0] video_data,
  output logic       valid,
  output logic [7:0] data,
  output logic       h_fall,
  output logic       v_fall,
  output cnt_t       sample_idx,
  output cnt_t       line_idx,
  output logic       err_now,
  output logic       locked,
  output logic       sync_error
);
  localparam int LW = $clog2(LOCK_N + 1);
  localparam cnt_t H_LAST = cnt_t'(H_TOT - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOT - 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_N);
  logic hs_r, vs_r, hs_p, vs_p, line_seen, frame_seen, lc_first, frame_bad;
  logic line_err, lines_ok, frame_err;
  cnt_t sc, lc;
  logic [LW-1:0] lock_cnt, lock_inc;
  // sample_idx/line_idx are the indices of the current sample/line, saturating
  always_comb begin
    h_fall     = valid & hs_p & ~hs_r;
    v_fall     = valid & vs_p & ~vs_r;
    sample_idx = h_fall ? '0 : (&sc ? sc : sc + 1'b1);
    line_idx   = (v_fall | lc_first) ? '0 : (&lc ? lc : lc + 1'b1);
    line_err   = h_fall & line_seen & (sc != H_LAST);
    lines_ok   = ~lc_first & (lc == V_LAST);
    frame_err  = v_fall & frame_seen & ~lines_ok;
    err_now    = line_err | frame_err;
    lock_inc   = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
  end
  // a frame containing a bad line is not counted towards lock but raises no second error
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      valid      <= 1'b0;
      data       <= '0;
      hs_r       <= 1'b1;
      vs_r       <= 1'b1;
      hs_p       <= 1'b1;
      vs_p       <= 1'b1;
      sc         <= '0;
      lc         <= '0;
      line_seen  <= 1'b0;
      frame_seen <= 1'b0;
      lc_first   <= 1'b0;
      frame_bad  <= 1'b0;
      lock_cnt   <= '0;
      locked     <= 1'b0;
      sync_error <= 1'b0;
    end else begin
      valid      <= pixel_valid;
      data       <= video_data;
      hs_r       <= h_sync;
      vs_r       <= v_sync;
      sync_error <= err_now;
      if (valid) begin
        hs_p       <= hs_r;
        vs_p       <= vs_r;
        sc         <= sample_idx;
        lc         <= h_fall ? line_idx : lc;
        lc_first   <= (v_fall | lc_first) & ~h_fall;
        line_seen  <= line_seen | h_fall;
        frame_seen <= frame_seen | v_fall;
        frame_bad  <= v_fall ? 1'b0 : frame_bad | line_err;
      end
      if (err_now) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end else if (v_fall && frame_seen && !frame_bad) begin
        lock_cnt <= lock_inc;
        locked   <= lock_inc == LOCK_MAX;
      end
    end
endmodule

// File: rtl/video_capture.sv
// video_capture: locks to VGA timing and emits 320x240 pixel-pair framebuffer writes
module video_capture
  import video_timing_pkg::*;
#(
  parameter int H_VIS   = H_VISIBLE_AREA,
  parameter int H_TOT   = H_TOTAL,
  parameter int H_START = H_ACTIVE_START,
  parameter int V_VIS   = V_VISIBLE_AREA,
  parameter int V_TOT   = V_TOTAL,
  parameter int V_START = V_ACTIVE_START,
  parameter int LOCK_N  = LOCK_FRAMES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pixelValid,
  input  logic       hSync,
  input  logic       vSync,
  input  logic [7:0] videoData,
  output logic       wrEnable,
  output logic [8:0] wrX,
  output logic [7:0] wrY,
  output logic [7:0] wrPixel1,
  output logic [7:0] wrPixel2,
  output logic       frameDone,
  output logic       locked,
  output logic       syncError
);
  localparam cnt_t LINE_START = cnt_t'(V_START);
  localparam cnt_t BLANK_LAST = cnt_t'(H_START - 1);
  localparam logic [9:0] COL_LAST = 10'(H_VIS - 1);
  localparam logic [8:0] ROW_LAST = 9'(V_VIS - 1);
  localparam logic [8:0] ROW_LAST_EVEN = 9'(V_VIS - 2);
  cap_state_t state, state_nxt, cur;
  logic valid, h_fall, v_fall, err_now, take, wr, row_clr, row_inc;
  logic [7:0] data, held;
  cnt_t sample_idx, line_idx;
  logic [9:0] col;
  logic [8:0] row;

  sync_monitor #(.H_TOT(H_TOT), .V_TOT(V_TOT), .LOCK_N(LOCK_N)) u_mon (
    .clock(clock), .reset(reset), .pixel_valid(pixelValid), .h_sync(hSync), .v_sync(vSync),
    .video_data(videoData), .valid(valid), .data(data), .h_fall(h_fall), .v_fall(v_fall),
    .sample_idx(sample_idx), .line_idx(line_idx), .err_now(err_now), .locked(locked),
    .sync_error(syncError)
  );

  // vSync fall is applied before the same sample's hSync fall
  always_comb begin
    cur       = v_fall ? VBLANK : state;
    state_nxt = state;
    row_clr   = 1'b0;
    row_inc   = 1'b0;
    if (valid) begin
      state_nxt = cur;
      case (cur)
        VBLANK:   if (h_fall && line_idx == LINE_START) begin
          state_nxt = HBLANK;
          row_clr   = 1'b1;
        end
        HBLANK:   if (sample_idx == BLANK_LAST) state_nxt = ACTIVE;
        ACTIVE:   if (col == COL_LAST) state_nxt = LINE_END;
        LINE_END: if (h_fall) begin
          state_nxt = (row == ROW_LAST) ? SEARCH : HBLANK;
          row_inc   = 1'b1;
        end
        default:  ;
      endcase
      if (err_now && !v_fall) state_nxt = SEARCH;
    end
    take = valid && state == ACTIVE && !v_fall && !h_fall;
    wr   = take && col[0] && !row[0] && locked;
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= SEARCH;
    else state <= state_nxt;

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      col       <= '0;
      row       <= '0;
      held      <= '0;
      wrEnable  <= 1'b0;
      wrX       <= '0;
      wrY       <= '0;
      wrPixel1  <= '0;
      wrPixel2  <= '0;
      frameDone <= 1'b0;
    end else begin
      wrEnable  <= wr;
      frameDone <= wr && col == COL_LAST && row == ROW_LAST_EVEN;
      col       <= take ? (col == COL_LAST ? '0 : col + 1'b1) : (state == ACTIVE ? col : '0);
      held      <= (take && !col[0]) ? data : held;
      row       <= row_clr ? '0 : (row_inc ? row + 1'b1 : row);
      if (wr) begin
        wrX      <= col[9:1];
        wrY      <= row[8:1];
        wrPixel1 <= held;
        wrPixel2 <= data;
      end
    end
endmodule
